// File: rtl/boot_copy_ctr_if.sv
// Bus bundle for boot_copy_ctr: the control slave port, the boot ROM read
// port and the SRAM write port.
//   slave  : the view used by boot_copy_ctr (answers control accesses,
//            reads the ROM, writes the SRAM)
//   master : the opposite view (CPU/control side, ROM and SRAM models)
// Signal names keep the _i/_o direction as seen from boot_copy_ctr.
interface boot_copy_ctr_if #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15,
    parameter int ROM_ADDR_W  = 12
);
    // control slave
    logic                    ctrl_avalid_i;
    logic [DATA_W-1:0]       ctrl_wdata_i;
    logic [DATA_W/8-1:0]     ctrl_wstrb_i;
    logic [DATA_W-1:0]       ctrl_rdata_o;
    logic                    ctrl_rvalid_o;
    logic                    ctrl_ready_o;

    // boot ROM read (word address, data one cycle after rom_en_o)
    logic                    rom_en_o;
    logic [ROM_ADDR_W-3:0]   rom_addr_o;
    logic [DATA_W-1:0]       rom_rdata_i;

    // SRAM write (word address)
    logic                    sram_avalid_o;
    logic [SRAM_ADDR_W-3:0]  sram_addr_o;
    logic [DATA_W-1:0]       sram_wdata_o;
    logic [DATA_W/8-1:0]     sram_wstrb_o;
    logic                    sram_ready_i;

    modport slave (
        input  ctrl_avalid_i, ctrl_wdata_i, ctrl_wstrb_i,
        output ctrl_rdata_o, ctrl_rvalid_o, ctrl_ready_o,
        output rom_en_o, rom_addr_o,
        input  rom_rdata_i,
        output sram_avalid_o, sram_addr_o, sram_wdata_o, sram_wstrb_o,
        input  sram_ready_i
    );

    modport master (
        output ctrl_avalid_i, ctrl_wdata_i, ctrl_wstrb_i,
        input  ctrl_rdata_o, ctrl_rvalid_o, ctrl_ready_o,
        input  rom_en_o, rom_addr_o,
        output rom_rdata_i,
        input  sram_avalid_o, sram_addr_o, sram_wdata_o, sram_wstrb_o,
        output sram_ready_i
    );
endinterface

// File: rtl/boot_copy_ctr.sv
// boot_copy_ctr: copies BOOT_WORDS words from the boot ROM into the top of
// SRAM, then pulses the CPU reset for RST_CYCLES cycles and releases the CPU.
// A control register in RUN lets software change boot mode (re-pulsing the
// CPU reset) or request a full recopy.
// Ports:
//   clk_i     clock
//   arst_i    asynchronous active-high reset (restarts the copy at word 0)
//   cke_i     clock enable; all state frozen while low
//   boot_o    boot mode flag
//   cpu_rst_o CPU reset, high in every state except RUN
//   bus       control slave / ROM read master / SRAM write master
module boot_copy_ctr #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15,
    parameter int ROM_ADDR_W  = 12,
    parameter int BOOT_WORDS  = 2**(ROM_ADDR_W-2),
    parameter int RST_CYCLES  = 8
) (
    input  logic           clk_i,
    input  logic           arst_i,
    input  logic           cke_i,
    output logic           boot_o,
    output logic           cpu_rst_o,
    boot_copy_ctr_if.slave bus
);

    localparam int SRAM_AW = SRAM_ADDR_W - 2;
    localparam int ROM_AW  = ROM_ADDR_W - 2;
    // BOOT_WORDS never exceeds either word space, so the narrower width
    // always holds the word counter.
    localparam int CNT_W   = (SRAM_AW < ROM_AW) ? SRAM_AW : ROM_AW;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BOOT_WORDS - 1);
    localparam logic [SRAM_AW-1:0] BASE      = SRAM_AW'(2**SRAM_AW - BOOT_WORDS);
    localparam logic [7:0]         RCNT_LAST = 8'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RD,
        ST_LD,
        ST_WR,
        ST_RST,
        ST_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rcnt_q, rcnt_d;
    logic               boot_q, boot_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

    logic               ctrl_wr;
    logic               ctrl_rd;
    logic               busy;
    logic               rom_en;
    logic               sram_avalid;
    logic [DATA_W/8-1:0] sram_wstrb;

    // only the two low control bits carry meaning
    logic               unused_wdata;
    assign unused_wdata = ^bus.ctrl_wdata_i[DATA_W-1:2];

    assign ctrl_wr = bus.ctrl_avalid_i &  (|bus.ctrl_wstrb_i);
    assign ctrl_rd = bus.ctrl_avalid_i & ~(|bus.ctrl_wstrb_i);
    assign busy    = (state_q != ST_RUN);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_RD;
            cnt_q    <= '0;
            rcnt_q   <= '0;
            boot_q   <= 1'b1;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            boot_q   <= boot_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rcnt_d      = rcnt_q;
        boot_d      = boot_q;
        wdata_d     = wdata_q;
        rom_en      = 1'b0;
        sram_avalid = 1'b0;
        sram_wstrb  = '0;

        unique case (state_q)
            ST_RD: begin
                rom_en  = 1'b1;
                state_d = ST_LD;
            end
            ST_LD: begin
                wdata_d = bus.rom_rdata_i;
                state_d = ST_WR;
            end
            ST_WR: begin
                // address/data come straight from registers, so they stay
                // put for as long as the SRAM stalls
                sram_avalid = 1'b1;
                sram_wstrb  = '1;
                if (bus.sram_ready_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RST;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RST: begin
                if (rcnt_q == RCNT_LAST) begin
                    rcnt_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (ctrl_wr) begin
                    if (bus.ctrl_wdata_i[1]) begin
                        boot_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RD;
                    end else if (bus.ctrl_wdata_i[0] != boot_q) begin
                        boot_d  = bus.ctrl_wdata_i[0];
                        state_d = ST_RST;
                    end
                end
            end
            default: state_d = ST_RD;
        endcase

        // read status is captured in the request cycle, answered next cycle
        rvalid_d = ctrl_rd;
        rdata_d  = ctrl_rd ? {{(DATA_W-2){1'b0}}, busy, boot_q} : rdata_q;
    end

    assign boot_o            = boot_q;
    assign cpu_rst_o         = busy;

    assign bus.ctrl_ready_o  = 1'b1;
    assign bus.ctrl_rvalid_o = rvalid_q;
    assign bus.ctrl_rdata_o  = rdata_q;

    assign bus.rom_en_o      = rom_en;
    assign bus.rom_addr_o    = ROM_AW'(cnt_q);

    assign bus.sram_avalid_o = sram_avalid;
    assign bus.sram_addr_o   = BASE + SRAM_AW'(cnt_q);
    assign bus.sram_wdata_o  = wdata_q;
    assign bus.sram_wstrb_o  = sram_wstrb;

endmodule

// File: tb/tb_boot_copy_ctr.sv
// Testbench for boot_copy_ctr with BOOT_WORDS=4, SRAM_ADDR_W=6 (BASE=12),
// RST_CYCLES=3. SRAM writes and control reads are checked against queues
// of expected results filled when the stimulus is driven.
module tb_boot_copy_ctr;

    logic clk = 1'b0;
    logic arst_i;
    logic cke_i;
    logic boot_o;
    logic cpu_rst_o;

    always #5 clk = ~clk;

    boot_copy_ctr_if #(.DATA_W(32), .SRAM_ADDR_W(6), .ROM_ADDR_W(12)) bus ();

    boot_copy_ctr #(
        .DATA_W      (32),
        .SRAM_ADDR_W (6),
        .ROM_ADDR_W  (12),
        .BOOT_WORDS  (4),
        .RST_CYCLES  (3)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst_i),
        .cke_i     (cke_i),
        .boot_o    (boot_o),
        .cpu_rst_o (cpu_rst_o),
        .bus       (bus)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_boot;
        int          exp_n;
        bit          reload;
    } vec_t;

    logic [31:0] rom_words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    wr_t         sb_wr[$];
    logic [31:0] sb_rd[$];

    int n_checks = 0;
    int n_errors = 0;

    int stall_addr = 0;
    int stall_left = 0;

    bit          held = 1'b0;
    logic [3:0]  prev_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // synchronous ROM: data valid the cycle after rom_en_o
    always @(posedge clk) begin
        if (bus.rom_en_o)
            bus.rom_rdata_i <= (bus.rom_addr_o < 10'd4) ? rom_words[bus.rom_addr_o[1:0]] : 32'hDEAD_BEEF;
    end

    // SRAM model with stall injection, and control read response checker
    always @(negedge clk) begin
        if (bus.sram_avalid_o) begin
            if (held) begin
                check("sram_hold_addr", 32'(bus.sram_addr_o), 32'(prev_addr));
                check("sram_hold_data", bus.sram_wdata_o, prev_data);
            end
            if (stall_left > 0 && int'(bus.sram_addr_o) == stall_addr) begin
                bus.sram_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.sram_ready_i = 1'b1;
            end
            if (bus.sram_ready_i) begin
                if (sb_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sram_unexpected: got write addr 0x%0h data 0x%0h expected none",
                             bus.sram_addr_o, bus.sram_wdata_o);
                end else begin
                    wr_t e;
                    e = sb_wr.pop_front();
                    check("sram_addr", 32'(bus.sram_addr_o), 32'(e.addr));
                    check("sram_data", bus.sram_wdata_o, e.data);
                    check("sram_wstrb", 32'(bus.sram_wstrb_o), 32'hF);
                end
            end
            held      = !bus.sram_ready_i;
            prev_addr = bus.sram_addr_o;
            prev_data = bus.sram_wdata_o;
        end else begin
            held             = 1'b0;
            bus.sram_ready_i = 1'b1;
        end

        if (bus.ctrl_rvalid_o) begin
            if (sb_rd.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected: got rvalid data 0x%0h expected none", bus.ctrl_rdata_o);
            end else begin
                check("rd_data", bus.ctrl_rdata_o, sb_rd.pop_front());
            end
        end
    end

    task automatic push_copy();
        for (int i = 0; i < 4; i++)
            sb_wr.push_back('{addr: 4'(12 + i), data: rom_words[i]});
    endtask

    task automatic ctrl_write(input logic [31:0] d, input logic [3:0] s);
        bus.ctrl_avalid_i = 1'b1;
        bus.ctrl_wdata_i  = d;
        bus.ctrl_wstrb_i  = s;
        @(negedge clk);
        bus.ctrl_avalid_i = 1'b0;
        bus.ctrl_wstrb_i  = 4'h0;
    endtask

    task automatic ctrl_read(input logic [31:0] exp);
        bus.ctrl_avalid_i = 1'b1;
        bus.ctrl_wdata_i  = 32'hFFFF_FFFF;
        bus.ctrl_wstrb_i  = 4'h0;
        sb_rd.push_back(exp);
        @(negedge clk);
        bus.ctrl_avalid_i = 1'b0;
    endtask

    // cycles until cpu_rst_o drops, bounded
    task automatic wait_run(output int n);
        n = 0;
        while (cpu_rst_o && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_en"},      32'(bus.rom_en_o), 32'd1);
        check({tag, "_rom_addr"},    32'(bus.rom_addr_o), 32'd0);
        check({tag, "_sram_avalid"}, 32'(bus.sram_avalid_o), 32'd0);
        check({tag, "_cpu_rst"},     32'(cpu_rst_o), 32'd1);
        check({tag, "_boot"},        32'(boot_o), 32'd1);
        check({tag, "_rvalid"},      32'(bus.ctrl_rvalid_o), 32'd0);
        check({tag, "_ready"},       32'(bus.ctrl_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   n;
        int   k;

        // {wdata, wstrb, boot after, cycles to RUN, recopy}
        vecs[0] = '{32'h0, 4'hF, 1'b0, 3,  1'b0};
        vecs[1] = '{32'h0, 4'hF, 1'b0, 0,  1'b0};
        vecs[2] = '{32'h2, 4'h1, 1'b1, 15, 1'b1};
        vecs[3] = '{32'h1, 4'hF, 1'b1, 0,  1'b0};
        vecs[4] = '{32'h0, 4'h8, 1'b0, 3,  1'b0};
        vecs[5] = '{32'h1, 4'hF, 1'b1, 3,  1'b0};
        vecs[6] = '{32'h3, 4'hF, 1'b1, 15, 1'b1};

        arst_i            = 1'b1;
        cke_i             = 1'b1;
        bus.ctrl_avalid_i = 1'b0;
        bus.ctrl_wdata_i  = 32'h0;
        bus.ctrl_wstrb_i  = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // initial copy after reset release
        push_copy();
        arst_i = 1'b0;
        wait_run(n);
        check("init_cycles", 32'(n), 32'd15);
        check("init_boot", 32'(boot_o), 32'd1);
        check("init_words_left", 32'(sb_wr.size()), 32'd0);

        // control writes in RUN
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].reload) push_copy();
            ctrl_write(vecs[i].wdata, vecs[i].wstrb);
            check("vec_rd_resp_left", 32'(sb_rd.size()), 32'd0);
            check("vec_boot_next", 32'(boot_o), 32'(vecs[i].exp_boot));
            wait_run(n);
            check("vec_cycles", 32'(n), 32'(vecs[i].exp_n));
            check("vec_words_left", 32'(sb_wr.size()), 32'd0);
            check("vec_ready", 32'(bus.ctrl_ready_o), 32'd1);
            ctrl_read({30'b0, 1'b0, vecs[i].exp_boot});
        end

        // recopy with a status read and an ignored write during the copy
        push_copy();
        ctrl_write(32'h3, 4'hF);
        ctrl_read(32'h3);
        ctrl_write(32'h0, 4'hF);
        wait_run(n);
        check("recopy_cycles", 32'(n), 32'd13);
        check("recopy_boot", 32'(boot_o), 32'd1);
        check("recopy_words_left", 32'(sb_wr.size()), 32'd0);
        check("recopy_rd_left", 32'(sb_rd.size()), 32'd0);

        // clock enable low for 4 cycles inside the CPU reset pulse
        ctrl_write(32'h0, 4'hF);
        cke_i = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            n++;
            check("cke_hold_cpu_rst", 32'(cpu_rst_o), 32'd1);
        end
        cke_i = 1'b1;
        begin
            int m;
            wait_run(m);
            n += m;
        end
        check("cke_cycles", 32'(n), 32'd7);
        check("cke_boot", 32'(boot_o), 32'd0);
        ctrl_read(32'h0);
        @(negedge clk);

        // reset-started copy with a 5-cycle SRAM stall on word 2
        arst_i = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst2");
        stall_addr = 14;
        stall_left = 5;
        push_copy();
        arst_i = 1'b0;
        wait_run(n);
        check("stall_cycles", 32'(n), 32'd20);
        check("stall_words_left", 32'(sb_wr.size()), 32'd0);

        // reset pulse while word 2 sits in WR
        stall_addr = 14;
        stall_left = 3;
        push_copy();
        ctrl_write(32'h3, 4'hF);
        k = 0;
        while (!(bus.sram_avalid_o && bus.sram_addr_o == 4'd14) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("midwr_reached", 32'(bus.sram_avalid_o && bus.sram_addr_o == 4'd14), 32'd1);
        arst_i = 1'b1;
        #1;
        check_reset_outputs("midwr");
        check("midwr_words_left", 32'(sb_wr.size()), 32'd2);
        stall_left = 0;
        sb_wr.delete();
        @(negedge clk);
        push_copy();
        arst_i = 1'b0;
        #1;
        check("restart_rom_en", 32'(bus.rom_en_o), 32'd1);
        check("restart_rom_addr", 32'(bus.rom_addr_o), 32'd0);
        @(negedge clk);
        begin
            int m;
            wait_run(m);
            n = m + 1;
        end
        check("restart_cycles", 32'(n), 32'd15);
        check("restart_words_left", 32'(sb_wr.size()), 32'd0);
        check("end_rd_left", 32'(sb_rd.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
